// File: rtl/alu_arbiter_if.sv
// Request, response and ALU-side signals of the shared ALU arbiter.
// master = requesters, response sink and ALU; slave = the arbiter.
interface alu_arbiter_if;
   logic        req0_valid;
   logic        req0_ready;
   logic [5:0]  req0_opcode;
   logic [15:0] req0_term1;
   logic [15:0] req0_term2;
   logic        req1_valid;
   logic        req1_ready;
   logic [5:0]  req1_opcode;
   logic [15:0] req1_term1;
   logic [15:0] req1_term2;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [15:0] rsp_result;
   logic [3:0]  rsp_flags;
   logic        rsp_err;
   logic        alu_enable;
   logic [5:0]  alu_opcode;
   logic [15:0] alu_term1;
   logic [15:0] alu_term2;
   logic [15:0] alu_result;
   logic        alu_fl_zero;
   logic        alu_fl_negative;
   logic        alu_fl_carry;
   logic        alu_fl_overflow;
   logic        alu_done;

   modport master (
      output req0_valid, req0_opcode,
      output req0_term1, req0_term2,
      input  req0_ready,
      output req1_valid, req1_opcode,
      output req1_term1, req1_term2,
      input  req1_ready,
      input  rsp_valid, rsp_id, rsp_result,
      input  rsp_flags, rsp_err,
      output rsp_ready,
      input  alu_enable, alu_opcode,
      input  alu_term1, alu_term2,
      output alu_result, alu_done,
      output alu_fl_zero, alu_fl_negative,
      output alu_fl_carry, alu_fl_overflow
   );

   modport slave (
      input  req0_valid, req0_opcode,
      input  req0_term1, req0_term2,
      output req0_ready,
      input  req1_valid, req1_opcode,
      input  req1_term1, req1_term2,
      output req1_ready,
      output rsp_valid, rsp_id, rsp_result,
      output rsp_flags, rsp_err,
      input  rsp_ready,
      output alu_enable, alu_opcode,
      output alu_term1, alu_term2,
      input  alu_result, alu_done,
      input  alu_fl_zero, alu_fl_negative,
      input  alu_fl_carry, alu_fl_overflow
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters,
// with done timeout, illegal-opcode rejection and a response channel.
module alu_arbiter #(
   parameter int unsigned TIMEOUT = 16,
   parameter logic [5:0]  MAX_OP  = 6'd17
) (
   input logic          clk,
   input logic          rst_b,
   alu_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_t;

   localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

   state_t      state;
   logic        prio;
   logic [7:0]  cnt;
   logic        idle;
   logic        grant;
   logic        take;
   logic [5:0]  sel_op;
   logic [15:0] sel_t1;
   logic [15:0] sel_t2;

   // ready is forced low while reset is held
   assign idle = (state == IDLE) && rst_b;

   // grant the sole requester, or the prio one on a tie
   always_comb begin
      grant = bus.req1_valid;
      if (bus.req0_valid && bus.req1_valid)
         grant = prio;
   end

   assign bus.req0_ready = idle && bus.req0_valid && !grant;
   assign bus.req1_ready = idle && bus.req1_valid && grant;
   assign take = bus.req0_ready || bus.req1_ready;

   assign sel_op = grant ? bus.req1_opcode : bus.req0_opcode;
   assign sel_t1 = grant ? bus.req1_term1 : bus.req0_term1;
   assign sel_t2 = grant ? bus.req1_term2 : bus.req0_term2;

   // arbitration FSM with registered ALU and response outputs
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state          <= IDLE;
         prio           <= 1'b0;
         cnt            <= 8'd0;
         bus.rsp_valid  <= 1'b0;
         bus.rsp_id     <= 1'b0;
         bus.rsp_result <= 16'd0;
         bus.rsp_flags  <= 4'd0;
         bus.rsp_err    <= 1'b0;
         bus.alu_enable <= 1'b0;
         bus.alu_opcode <= 6'd0;
         bus.alu_term1  <= 16'd0;
         bus.alu_term2  <= 16'd0;
      end else begin
         unique case (state)
            IDLE: begin
               if (take) begin
                  bus.rsp_id <= grant;
                  prio       <= ~grant;
                  if (sel_op > MAX_OP) begin
                     state          <= RESP;
                     bus.rsp_valid  <= 1'b1;
                     bus.rsp_err    <= 1'b1;
                     bus.rsp_result <= 16'd0;
                     bus.rsp_flags  <= 4'd0;
                  end else begin
                     state          <= BUSY;
                     cnt            <= 8'd0;
                     bus.alu_enable <= 1'b1;
                     bus.alu_opcode <= sel_op;
                     bus.alu_term1  <= sel_t1;
                     bus.alu_term2  <= sel_t2;
                  end
               end
            end
            BUSY: begin
               if (bus.alu_done) begin
                  state          <= RESP;
                  bus.alu_enable <= 1'b0;
                  bus.rsp_valid  <= 1'b1;
                  bus.rsp_err    <= 1'b0;
                  bus.rsp_result <= bus.alu_result;
                  bus.rsp_flags  <= {bus.alu_fl_overflow,
                                     bus.alu_fl_carry,
                                     bus.alu_fl_negative,
                                     bus.alu_fl_zero};
               end else if (cnt == LAST) begin
                  state          <= RESP;
                  bus.alu_enable <= 1'b0;
                  bus.rsp_valid  <= 1'b1;
                  bus.rsp_err    <= 1'b1;
                  bus.rsp_result <= 16'd0;
                  bus.rsp_flags  <= 4'd0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  state         <= IDLE;
                  bus.rsp_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: ALU model, response scoreboard,
// latency / arbitration / timeout / backpressure / reset checks.
module tb_alu_arbiter;
   typedef struct {
      logic        id;
      logic [15:0] res;
      logic [3:0]  fl;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic rst_b;
   int   done_dly;
   int   ecnt;
   int   n_chk = 0;
   int   n_fail = 0;
   int   n_rsp = 0;
   exp_t sb[$];

   logic [15:0] m_res;
   logic        m_c;
   logic        m_v;
   logic [16:0] m_sum;

   always #5 clk = ~clk;

   alu_arbiter_if bus ();

   alu_arbiter #(
      .TIMEOUT(8),
      .MAX_OP (6'd17)
   ) dut (
      .clk  (clk),
      .rst_b(rst_b),
      .bus  (bus)
   );

   // ALU model: counts enabled cycles, done after done_dly of them
   always @(posedge clk or negedge rst_b) begin
      if (!rst_b) ecnt <= 0;
      else        ecnt <= bus.alu_enable ? ecnt + 1 : 0;
   end

   always_comb begin
      m_sum = 17'(bus.alu_term1) + 17'(bus.alu_term2);
      m_res = 16'd0;
      m_c   = 1'b0;
      m_v   = 1'b0;
      case (bus.alu_opcode)
         6'd0: begin
            m_res = m_sum[15:0];
            m_c   = m_sum[16];
            m_v   = (bus.alu_term1[15] == bus.alu_term2[15]) &&
                    (m_sum[15] != bus.alu_term1[15]);
         end
         6'd1:  m_res = bus.alu_term1 - bus.alu_term2;
         6'd2:  m_res = 16'(bus.alu_term1 * bus.alu_term2);
         6'd16: m_res = bus.alu_term1 + 16'd1;
         6'd17: m_res = bus.alu_term1 - 16'd1;
         default: m_res = 16'd0;
      endcase
   end

   assign bus.alu_result      = m_res;
   assign bus.alu_fl_zero     = (m_res == 16'd0);
   assign bus.alu_fl_negative = m_res[15];
   assign bus.alu_fl_carry    = m_c;
   assign bus.alu_fl_overflow = m_v;
   assign bus.alu_done = bus.alu_enable && (done_dly >= 0) &&
                         (ecnt == done_dly);

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic id, input logic [15:0] res,
                               input logic [3:0] fl, input logic err);
      exp_t e;
      e.id  = id;
      e.res = res;
      e.fl  = fl;
      e.err = err;
      return e;
   endfunction

   // response monitor: pop expected on each handshake
   always @(negedge clk) begin
      if (rst_b && bus.rsp_valid && bus.rsp_ready) begin
         n_rsp++;
         if (sb.size() == 0) begin
            chk("rsp_unexpected", 32'(sb.size()), 32'd1);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
            chk("rsp_result", 32'(bus.rsp_result), 32'(e.res));
            chk("rsp_flags", 32'(bus.rsp_flags), 32'(e.fl));
            chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic id, input logic [5:0] op,
                        input logic [15:0] a, input logic [15:0] b);
      if (id) begin
         bus.req1_opcode = op;
         bus.req1_term1  = a;
         bus.req1_term2  = b;
         bus.req1_valid  = 1'b1;
      end else begin
         bus.req0_opcode = op;
         bus.req0_term1  = a;
         bus.req0_term2  = b;
         bus.req0_valid  = 1'b1;
      end
   endtask

   // drive one request, push its expectation, return after accept edge
   task automatic send(input logic id, input logic [5:0] op,
                       input logic [15:0] a, input logic [15:0] b,
                       input exp_t e);
      int n;
      n = 0;
      drive(id, op, a, b);
      @(negedge clk);
      while (!(id ? bus.req1_ready : bus.req0_ready) && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("accept_wait", 32'(n < 50), 32'd1);
      sb.push_back(e);
      tick();
      if (id) bus.req1_valid = 1'b0;
      else    bus.req0_valid = 1'b0;
   endtask

   // enabled cycles from accept until rsp_valid rises
   task automatic count_en(output int n);
      int k;
      n = 0;
      k = 0;
      @(negedge clk);
      while (!bus.rsp_valid && k < 40) begin
         if (bus.alu_enable) n++;
         @(negedge clk);
         k++;
      end
      chk("rsp_wait", 32'(bus.rsp_valid), 32'd1);
      chk("en_at_rsp", 32'(bus.alu_enable), 32'd0);
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (sb.size() != 0 && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("drain_wait", 32'(k < 100), 32'd1);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n;
      int   nacc;
      int   base;
      logic [3:0] ord;

      rst_b           = 1'b0;
      done_dly        = 0;
      bus.req0_valid  = 1'b1;
      bus.req1_valid  = 1'b1;
      bus.req0_opcode = 6'd0;
      bus.req0_term1  = 16'd0;
      bus.req0_term2  = 16'd0;
      bus.req1_opcode = 6'd0;
      bus.req1_term1  = 16'd0;
      bus.req1_term2  = 16'd0;
      bus.rsp_ready   = 1'b1;
      #12;
      chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
      chk("rst_ready1", 32'(bus.req1_ready), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
      chk("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
      chk("rst_rsp_flags", 32'(bus.rsp_flags), 32'd0);
      chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      chk("rst_alu_enable", 32'(bus.alu_enable), 32'd0);
      chk("rst_alu_opcode", 32'(bus.alu_opcode), 32'd0);
      chk("rst_alu_term1", 32'(bus.alu_term1), 32'd0);
      chk("rst_alu_term2", 32'(bus.alu_term2), 32'd0);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      @(negedge clk);
      rst_b = 1'b1;
      tick();

      send(1'b0, 6'd0, 16'd5, 16'd10, mk(1'b0, 16'd15, 4'd0, 1'b0));
      count_en(n);
      chk("happy_latency", 32'(n), 32'd1);
      wait_idle();
      send(1'b0, 6'd0, 16'hFFFF, 16'd1, mk(1'b0, 16'd0, 4'b0101, 1'b0));
      wait_idle();
      send(1'b0, 6'd0, 16'h7FFF, 16'd1,
           mk(1'b0, 16'h8000, 4'b1010, 1'b0));
      wait_idle();
      send(1'b0, 6'd1, 16'd1, 16'd2, mk(1'b0, 16'hFFFF, 4'b0010, 1'b0));
      wait_idle();

      done_dly = -1;
      send(1'b0, 6'd0, 16'd1, 16'd2, mk(1'b0, 16'd0, 4'd0, 1'b1));
      @(negedge clk);
      chk("mid_busy_en", 32'(bus.alu_enable), 32'd1);
      @(negedge clk);
      #2;
      rst_b = 1'b0;
      #1;
      chk("mid_rst_en", 32'(bus.alu_enable), 32'd0);
      chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      sb.delete();
      @(negedge clk);
      rst_b = 1'b1;
      base = n_rsp;
      repeat (12) @(negedge clk);
      chk("mid_rst_no_rsp", 32'(n_rsp - base), 32'd0);
      chk("mid_rst_idle_en", 32'(bus.alu_enable), 32'd0);
      done_dly = 0;
      tick();

      drive(1'b0, 6'd1, 16'd16, 16'd10);
      drive(1'b1, 6'd2, 16'd5, 16'd10);
      nacc = 0;
      ord  = 4'd0;
      n    = 0;
      while (nacc < 4 && n < 60) begin
         @(negedge clk);
         chk("ready_onehot",
             32'(bus.req0_ready & bus.req1_ready), 32'd0);
         if (bus.req0_ready) begin
            sb.push_back(mk(1'b0, 16'd6, 4'd0, 1'b0));
            ord[nacc] = 1'b0;
            nacc++;
         end else if (bus.req1_ready) begin
            sb.push_back(mk(1'b1, 16'd50, 4'd0, 1'b0));
            ord[nacc] = 1'b1;
            nacc++;
         end
         n++;
      end
      tick();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      chk("grant_count", 32'(nacc), 32'd4);
      chk("grant_order", 32'(ord), 32'b1010);
      wait_idle();

      send(1'b1, 6'd18, 16'd3, 16'd4, mk(1'b1, 16'd0, 4'd0, 1'b1));
      count_en(n);
      chk("illegal_en_cycles", 32'(n), 32'd0);
      wait_idle();

      done_dly = -1;
      send(1'b0, 6'd0, 16'd1, 16'd1, mk(1'b0, 16'd0, 4'd0, 1'b1));
      count_en(n);
      chk("timeout_en_cycles", 32'(n), 32'd8);
      wait_idle();
      done_dly = 0;
      send(1'b0, 6'd16, 16'd1, 16'd0, mk(1'b0, 16'd2, 4'd0, 1'b0));
      wait_idle();
      done_dly = 7;
      send(1'b0, 6'd0, 16'd3, 16'd4, mk(1'b0, 16'd7, 4'd0, 1'b0));
      count_en(n);
      chk("late_done_en_cycles", 32'(n), 32'd8);
      wait_idle();
      done_dly = 0;

      bus.rsp_ready = 1'b0;
      send(1'b0, 6'd0, 16'd2, 16'd3, mk(1'b0, 16'd5, 4'd0, 1'b0));
      drive(1'b1, 6'd16, 16'd9, 16'd0);
      count_en(n);
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
         chk("bp_ready1", 32'(bus.req1_ready), 32'd0);
         chk("bp_result", 32'(bus.rsp_result), 32'd5);
         chk("bp_id", 32'(bus.rsp_id), 32'd0);
         chk("bp_err", 32'(bus.rsp_err), 32'd0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_rise_ready1", 32'(bus.req1_ready), 32'd0);
      @(negedge clk);
      chk("bp_next_ready1", 32'(bus.req1_ready), 32'd1);
      if (bus.req1_ready) sb.push_back(mk(1'b1, 16'd10, 4'd0, 1'b0));
      tick();
      bus.req1_valid = 1'b0;
      wait_idle();

      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      chk("rsp_count", 32'(n_rsp), 32'd14);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
